ring_decoder_monitor: RTL and testbench
=======================================

# ring_decoder_monitor

Receive-side companion to the one-hot ring counter. It samples a WIDTH-bit ring code every enabled clock and registers its binary index. It also checks that the sequence advances legally (hold or rotate-left by one), locks onto a healthy ring, flags sequence faults, and counts full revolutions. It sits downstream of any ring counter whose `q` must be decoded or supervised.

## Interface
- `WIDTH`, 4: ring length in bits, ≥2.
- `LOCK_STEPS`, 2: consecutive legal steps required to declare lock, 1..15.
- `CW`, 8: revolution counter width.
- `clk  input  1`: rising-edge clock.
- `clr_n  input  1`: asynchronous, active-low reset. One clock; the reset is asynchronous and active-low.
- `en  input  1`: sample qualifier. When low, all state and outputs hold.
- `q  input  WIDTH`: ring code under observation.
- `idx  output  $clog2(WIDTH)`: binary index of the last valid one-hot code.
- `code_ok  output  1`: last sample was exactly one-hot.
- `locked  output  1`: FSM in LOCKED.
- `step_err  output  1`: one-cycle pulse on a sequence fault while LOCKED.
- `rev_cnt  output  CW`: completed revolutions while LOCKED, modulo 2^CW.
- `err_cnt  output  8`: saturating fault count. Present only under the macro; tied to 0 otherwise.

## Operation
- All outputs are registered. Reset values: `idx`=0, `code_ok`=0, `locked`=0, `step_err`=0, `rev_cnt`=0, `err_cnt`=0. Also at reset: `prev`=0, step count=0, state SEARCH.
- Each sample with `en`=1 is classified against `prev`, the last valid code:
  - VALID: `q` has exactly one bit set.
  - HOLD: `q`==`prev`.
  - STEP: `q`==rotate-left(`prev`), i.e. bit WIDTH-1 wraps to bit 0.
  - BAD: anything else, including an invalid code.
- On every VALID sample, `prev` and `idx` update to `q`. On an invalid sample, `idx` and `prev` hold.
- FSM:
  - SEARCH: VALID → ACQ with count=0. Invalid → stay.
  - ACQ: STEP increments count; when count reaches LOCK_STEPS, go to LOCKED. HOLD keeps the count. BAD with a VALID code → stay in ACQ with count=0. Invalid → SEARCH.
  - LOCKED: STEP or HOLD → stay. BAD → FAULT, pulse `step_err`, increment `err_cnt`.
  - FAULT: a HOLD or STEP against the updated `prev` → ACQ (count=1 on STEP, 0 on HOLD). Any other VALID code → stay in FAULT. Invalid → stay.
- `rev_cnt` increments on a STEP while LOCKED whose `prev` had bit WIDTH-1 set. It wraps silently and is cleared only by reset.
- `step_err` never asserts outside LOCKED. Faults during acquisition are silent.

## Timing
- Latency: `q` sampled at edge N appears on `idx`/`code_ok`/`locked`/`step_err`/`rev_cnt` after edge N (visible in cycle N+1).
- Lock: with the ring stepping every cycle from a valid start, `locked` rises LOCK_STEPS+1 cycles after the first valid sample.
- `en`=0 cycles are invisible: no classification, `step_err` forced 0, all counters hold.
- `clr_n` low mid-run immediately forces all reset values regardless of `clk`. Release is taken on the next edge after deassertion.
- Simultaneous STEP-wrap and lock entry in ACQ: no `rev_cnt` increment, because increments require being already LOCKED.

## Configuration
- `RING_MON_ERRCNT_EN` defined: `err_cnt` is an 8-bit counter that increments on each `step_err` pulse and saturates at 255.
- Undefined: no counter logic; `err_cnt` is driven constant 0. The port list is identical in both builds.

## Test plan
- Reset/idle (WIDTH=4, LOCK_STEPS=2): hold `clr_n`=0 → every output is 0. With `q`=0000 and `en`=1 → stays SEARCH, `code_ok`=0, no `step_err`.
- Lock: `q`=0001,0010,0100,1000,0001 on consecutive cycles → `idx`=0,1,2,3,0. `locked`=1 from the cycle after 0100 is sampled. `rev_cnt`=1 after 0001 is sampled.
- Ring cleared mid-run: locked at 0100, then `q`=0001 → `step_err` pulses once and `locked` drops. Then 0010 → ACQ. Then 0100 → `locked`=1 again. `err_cnt`=1 with the macro, 0 without.
- Hold tolerance: locked ring held at 0010 for 10 cycles, then 0100 → no `step_err`, `locked` stays 1, `idx` 1→2.
- Illegal code: locked, then `q`=0110 → `step_err` pulse, `code_ok`=0, `idx` holds. Then 1000 → still FAULT (BAD against `prev`). Then 0001 → ACQ.
- Enable gating and async reset: toggle `en`=0 for 3 cycles while `q` jumps arbitrarily → no output change. Pulse `clr_n` low between clock edges → outputs zero immediately.

Source files
------------

// File: rtl/ring_decoder_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : ring_decoder_monitor_if
// Purpose  : Bundles the sample-side inputs and the status outputs of the
//            ring decoder/monitor into one interface.
// Ports    : en       - sample qualifier (master -> slave)
//            q        - ring code under observation (master -> slave)
//            idx      - binary index of last valid one-hot code (slave -> master)
//            code_ok  - last sample was exactly one-hot
//            locked   - monitor is locked onto a healthy ring
//            step_err - one-cycle sequence-fault pulse while locked
//            rev_cnt  - completed revolutions while locked (wraps)
//            err_cnt  - saturating fault count (0 unless RING_MON_ERRCNT_EN)
// Modports : master - the ring source / observer side
//            slave  - the monitor itself
// Revision : 1.0 - initial release
// ============================================================================
interface ring_decoder_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 8
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             en;
  logic [WIDTH-1:0] q;
  logic [IW-1:0]    idx;
  logic             code_ok;
  logic             locked;
  logic             step_err;
  logic [CW-1:0]    rev_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output en, q,
    input  idx, code_ok, locked, step_err, rev_cnt, err_cnt
  );

  modport slave (
    input  en, q,
    output idx, code_ok, locked, step_err, rev_cnt, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ring_decoder_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ring_decoder_monitor
// Purpose  : Decodes a WIDTH-bit one-hot ring code into a binary index and
//            supervises the sequence: each enabled sample must hold or rotate
//            left by one. Locks after LOCK_STEPS consecutive legal steps,
//            flags faults while locked, and counts full revolutions.
// Ports    : clk   - rising-edge clock
//            clr_n - asynchronous active-low reset
//            mon   - ring_decoder_monitor_if.slave (en, q in; status out)
// Params   : WIDTH      - ring length in bits (>= 2)
//            LOCK_STEPS - consecutive legal steps needed for lock (1..15)
//            CW         - revolution counter width
// Macro    : RING_MON_ERRCNT_EN - when defined, err_cnt is an 8-bit
//            saturating count of step_err pulses; otherwise err_cnt is 0.
// Revision : 1.0 - initial release
// ============================================================================
module ring_decoder_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 2,
  parameter int CW         = 8
) (
  input  wire logic               clk,
  input  wire logic               clr_n,
  ring_decoder_monitor_if.slave   mon
);

  localparam int               IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
  localparam logic [3:0]       C_LOCK   = 4'(LOCK_STEPS);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] prev_q;
  logic [IW-1:0]    idx_q;
  logic             code_ok_q;
  logic             locked_q;
  logic             step_err_q, step_err_d;
  logic [CW-1:0]    rev_cnt_q;
  logic             rev_inc;

  // --------------------------------------------------------------------------
  // Sample classification
  // --------------------------------------------------------------------------
  logic             is_valid;
  logic             is_hold;
  logic             is_step;
  logic [WIDTH-1:0] prev_rot;
  logic [IW-1:0]    idx_enc;

  always_comb begin
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    is_valid = (mon.q != '0) && ((mon.q & (mon.q - C_ONE)) == '0);
    prev_rot = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    // prev is 0 only before the first valid sample; requiring a valid code
    // keeps an all-zero sample from looking like HOLD/STEP against it.
    is_hold  = is_valid && (mon.q == prev_q);
    is_step  = is_valid && (mon.q == prev_rot);

    // OR-reduction encoder; only meaningful (and only used) for one-hot q.
    idx_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mon.q[i]) begin
        idx_enc = idx_enc | IW'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / pulse logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_err_d = 1'b0;
    rev_inc    = 1'b0;

    if (mon.en) begin
      case (state_q)
        S_SEARCH: begin
          if (is_valid) begin
            state_d = S_ACQ;
            cnt_d   = 4'd0;
          end
        end

        S_ACQ: begin
          if (is_step) begin
            cnt_d = cnt_q + 4'd1;
            // >= so that a count re-entering ACQ at 1 still locks when
            // LOCK_STEPS is 1.
            if ((cnt_q + 4'd1) >= C_LOCK) begin
              state_d = S_LOCKED;
            end
          end else if (is_hold) begin
            cnt_d = cnt_q;
          end else if (is_valid) begin
            cnt_d = 4'd0;
          end else begin
            state_d = S_SEARCH;
            cnt_d   = 4'd0;
          end
        end

        S_LOCKED: begin
          if (is_step) begin
            // Wrapping out of the top bit completes one revolution.
            rev_inc = prev_q[WIDTH-1];
          end else if (!is_hold) begin
            state_d    = S_FAULT;
            step_err_d = 1'b1;
          end
        end

        S_FAULT: begin
          // prev has already absorbed the faulting code if it was valid,
          // so recovery is judged against the new position.
          if (is_step) begin
            state_d = S_ACQ;
            cnt_d   = 4'd1;
          end else if (is_hold) begin
            state_d = S_ACQ;
            cnt_d   = 4'd0;
          end
        end

        default: begin
          state_d = S_SEARCH;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_SEARCH;
      cnt_q      <= 4'd0;
      prev_q     <= '0;
      idx_q      <= '0;
      code_ok_q  <= 1'b0;
      locked_q   <= 1'b0;
      step_err_q <= 1'b0;
      rev_cnt_q  <= '0;
    end else if (mon.en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_ok_q  <= is_valid;
      locked_q   <= (state_d == S_LOCKED);
      step_err_q <= step_err_d;
      rev_cnt_q  <= rev_cnt_q + CW'(rev_inc);
      if (is_valid) begin
        prev_q <= mon.q;
        idx_q  <= idx_enc;
      end
    end else begin
      // A disabled cycle never carries a fault pulse forward.
      step_err_q <= 1'b0;
    end
  end

  assign mon.idx      = idx_q;
  assign mon.code_ok  = code_ok_q;
  assign mon.locked   = locked_q;
  assign mon.step_err = step_err_q;
  assign mon.rev_cnt  = rev_cnt_q;

  // --------------------------------------------------------------------------
  // Optional saturating fault counter
  // --------------------------------------------------------------------------
`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside the step_err pulse so both become visible together.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_cnt_q <= 8'd0;
    end else if (mon.en && step_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign mon.err_cnt = err_cnt_q;
`else
  assign mon.err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_decoder_monitor
// Purpose  : Directed, self-checking bench for ring_decoder_monitor with
//            WIDTH=4, LOCK_STEPS=2, CW=8. Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_decoder_monitor;

  localparam int WIDTH      = 4;
  localparam int LOCK_STEPS = 2;
  localparam int CW         = 8;

`ifdef RING_MON_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  always #5 clk = ~clk;

  ring_decoder_monitor_if #(.WIDTH(WIDTH), .CW(CW)) mon_if ();

  ring_decoder_monitor #(
    .WIDTH      (WIDTH),
    .LOCK_STEPS (LOCK_STEPS),
    .CW         (CW)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .mon   (mon_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected err_cnt given the number of locked-state faults so far.
  function automatic int exp_err(input int faults);
    return ERRCNT_ON ? faults : 0;
  endfunction

  task automatic check_all(input string tag, input int e_idx, input int e_ok,
                           input int e_lk, input int e_se, input int e_rev,
                           input int e_err);
    check({tag, ".idx"},      32'(mon_if.idx),      32'(e_idx));
    check({tag, ".code_ok"},  32'(mon_if.code_ok),  32'(e_ok));
    check({tag, ".locked"},   32'(mon_if.locked),   32'(e_lk));
    check({tag, ".step_err"}, 32'(mon_if.step_err), 32'(e_se));
    check({tag, ".rev_cnt"},  32'(mon_if.rev_cnt),  32'(e_rev));
    check({tag, ".err_cnt"},  32'(mon_if.err_cnt),  32'(e_err));
  endtask

  // Apply one sample at the falling edge, let it be taken on the rising
  // edge, and return 1 time unit later for checking.
  task automatic drive(input logic e, input logic [WIDTH-1:0] code);
    @(negedge clk);
    mon_if.en = e;
    mon_if.q  = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mon_if.en = 1'b0;
    mon_if.q  = '0;

    // Reset held
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;

    // Idle: all-zero code keeps the monitor searching
    drive(1'b1, 4'b0000); check_all("idle", 0, 0, 0, 0, 0, 0);

    // Lock sequence
    drive(1'b1, 4'b0001); check_all("lock0001", 0, 1, 0, 0, 0, 0);
    drive(1'b1, 4'b0010); check_all("lock0010", 1, 1, 0, 0, 0, 0);
    drive(1'b1, 4'b0100); check_all("lock0100", 2, 1, 1, 0, 0, 0);
    drive(1'b1, 4'b1000); check_all("lock1000", 3, 1, 1, 0, 0, 0);
    drive(1'b1, 4'b0001); check_all("rev1",     0, 1, 1, 0, 1, 0);
    drive(1'b1, 4'b0010); check_all("run0010",  1, 1, 1, 0, 1, 0);
    drive(1'b1, 4'b0100); check_all("run0100",  2, 1, 1, 0, 1, 0);

    // Ring cleared mid-run: 0100 -> 0001 is a fault, then reacquire
    drive(1'b1, 4'b0001); check_all("clr_fault", 0, 1, 0, 1, 1, exp_err(1));
    drive(1'b1, 4'b0010); check_all("clr_acq",   1, 1, 0, 0, 1, exp_err(1));
    drive(1'b1, 4'b0100); check_all("clr_relock",2, 1, 1, 0, 1, exp_err(1));
    drive(1'b1, 4'b1000); check_all("run1000b",  3, 1, 1, 0, 1, exp_err(1));
    drive(1'b1, 4'b0001); check_all("rev2",      0, 1, 1, 0, 2, exp_err(1));
    drive(1'b1, 4'b0010); check_all("run0010b",  1, 1, 1, 0, 2, exp_err(1));

    // Hold tolerance
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0010); check_all("hold", 1, 1, 1, 0, 2, exp_err(1));
    end
    drive(1'b1, 4'b0100); check_all("hold_step", 2, 1, 1, 0, 2, exp_err(1));
    drive(1'b1, 4'b1000); check_all("run1000c",  3, 1, 1, 0, 2, exp_err(1));
    drive(1'b1, 4'b0001); check_all("rev3",      0, 1, 1, 0, 3, exp_err(1));
    drive(1'b1, 4'b0010); check_all("run0010c",  1, 1, 1, 0, 3, exp_err(1));

    // Illegal code while locked at 0010
    drive(1'b1, 4'b0110); check_all("illegal",   1, 0, 0, 1, 3, exp_err(2));
    drive(1'b1, 4'b1000); check_all("fault_bad", 3, 1, 0, 0, 3, exp_err(2));
    drive(1'b1, 4'b0001); check_all("fault_acq", 0, 1, 0, 0, 3, exp_err(2));
    // Recovery STEP entered ACQ at count 1, so one more step locks
    drive(1'b1, 4'b0010); check_all("fault_lock",1, 1, 1, 0, 3, exp_err(2));

    // Enable gating: arbitrary codes with en=0 change nothing
    drive(1'b0, 4'b0110); check_all("gate0", 1, 1, 1, 0, 3, exp_err(2));
    drive(1'b0, 4'b1000); check_all("gate1", 1, 1, 1, 0, 3, exp_err(2));
    drive(1'b0, 4'b0000); check_all("gate2", 1, 1, 1, 0, 3, exp_err(2));
    drive(1'b1, 4'b0100); check_all("gate_step", 2, 1, 1, 0, 3, exp_err(2));

    // Fault pulse then a disabled cycle clears step_err only
    drive(1'b1, 4'b0000); check_all("zero_fault", 2, 0, 0, 1, 3, exp_err(3));
    drive(1'b0, 4'b0101); check_all("gate_se",    2, 0, 0, 0, 3, exp_err(3));

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;

    // Lock entry coinciding with a wrap step must not count a revolution
    drive(1'b1, 4'b0100); check_all("wrap0100", 2, 1, 0, 0, 0, 0);
    drive(1'b1, 4'b1000); check_all("wrap1000", 3, 1, 0, 0, 0, 0);
    drive(1'b1, 4'b0001); check_all("wrap_lock",0, 1, 1, 0, 0, 0);
    drive(1'b1, 4'b0010);
    drive(1'b1, 4'b0100);
    drive(1'b1, 4'b1000); check_all("wrap_pre", 3, 1, 1, 0, 0, 0);
    drive(1'b1, 4'b0001); check_all("wrap_rev", 0, 1, 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
